// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types, constants and hex decode for the seven-segment scanner
// Contents: seg7_t (segments {g,f,e,d,c,b,a}, active-low), SEG_BLANK, hex_to_seg().
package sevenseg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // Active-low decode; lower-case glyphs for b and d keep them distinct from 8 and 0.
    function automatic seg7_t hex_to_seg(input logic [3:0] nib);
        seg7_t s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - control and display bundle for sevenseg_scan
// Driver side: en, load, value_in (digit 0 = [3:0]), dp_in.
// Display side: seg, dp, an (all active-low), frame_start.
// modport master = driver/bench, modport slave = sevenseg_scan.
interface sevenseg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    import sevenseg_pkg::*;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    seg7_t                   seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output en, load, value_in, dp_in,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  en, load, value_in, dp_in,
        output seg, dp, an, frame_start
    );

endinterface

// File: rtl/sevenseg_prescaler.sv
// rtl/sevenseg_prescaler.sv - slot prescaler and digit counter for the scanner
// Inputs : clk, rst (sync, active-high), en (0 holds both counters at 0).
// Outputs: index (current digit), slot_blank (anti-ghost window),
//          slot_first (digit 0, cycle 0), frame_boundary (last cycle of last digit).
module sevenseg_prescaler #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int PW = $clog2(DIV_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [IW-1:0] index,
    output logic          slot_blank,
    output logic          slot_first,
    output logic          frame_boundary
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          slot_end;

    assign slot_end = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign slot_blank = 1'b0;
        end else begin : g_blank
            assign slot_blank = (presc < PW'(BLANK_CYCLES));
        end
    endgenerate

    assign index          = idx;
    assign slot_first     = (presc == '0) && (idx == '0);
    assign frame_boundary = en && slot_end && (idx == IDX_LAST);

endmodule

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - N-digit multiplexed common-anode seven-segment driver
// Ports: clk, rst (sync, active-high), bus (sevenseg_scan_if.slave):
//        en, load, value_in, dp_in in; seg, dp, an, frame_start out (registered).
// Optional macro SEVENSEG_LZB_EN: leading-zero blanking of the segments.
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    sevenseg_scan_if.slave bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [IW-1:0] index;
    logic          slot_blank;
    logic          slot_first;
    logic          frame_boundary;

    sevenseg_prescaler #(
        .NUM_DIGITS   (NUM_DIGITS),
        .DIV_CYCLES   (DIV_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk            (clk),
        .rst            (rst),
        .en             (bus.en),
        .index          (index),
        .slot_blank     (slot_blank),
        .slot_first     (slot_first),
        .frame_boundary (frame_boundary)
    );

    logic [VW-1:0]         pend_val, act_val;
    logic [NUM_DIGITS-1:0] pend_dp,  act_dp;

    // While disabled every cycle acts as a frame boundary, so re-enable
    // always starts from the most recent load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val <= '0;
            pend_dp  <= '0;
            act_val  <= '0;
            act_dp   <= '0;
        end else begin
            if (bus.load) begin
                pend_val <= bus.value_in;
                pend_dp  <= bus.dp_in;
            end
            if (frame_boundary || !bus.en) begin
                act_val <= bus.load ? bus.value_in : pend_val;
                act_dp  <= bus.load ? bus.dp_in    : pend_dp;
            end
        end
    end

    logic [3:0] nib;
    logic       lz_blank;

    assign nib = act_val[{index, 2'b00} +: 4];

`ifdef SEVENSEG_LZB_EN
    // Highest non-zero digit; stays 0 for an all-zero value so digit 0 always shows.
    logic [IW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (act_val[4*i +: 4] != 4'h0) begin
                msd = IW'(i);
            end
        end
    end

    assign lz_blank = (index > msd);
`else
    assign lz_blank = 1'b0;
`endif

    seg7_t                 seg_d,  seg_q;
    logic                  dp_d,   dp_q;
    logic [NUM_DIGITS-1:0] an_d,   an_q;
    logic                  fs_q;

    // Blanked digits still drive their anode so slot timing and dp are unchanged.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (bus.en && !slot_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << index);
            seg_d = lz_blank ? SEG_BLANK : hex_to_seg(nib);
            dp_d  = ~act_dp[index];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fs_q  <= bus.en && slot_first;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb/tb_sevenseg_scan.sv - self-checking bench for sevenseg_scan against a cycle-count reference model
module tb_sevenseg_scan;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int B  = 1;
    localparam int VW = 4 * N;
    localparam int FRAME = D * N;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sevenseg_scan_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_scan #(
        .NUM_DIGITS   (N),
        .DIV_CYCLES   (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Glyph table written from the display's character set.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference state: cycles elapsed in the running scan (mod one frame), buffers.
    int            cnt = 0;
    logic [VW-1:0] m_pend = '0, m_act = '0;
    logic [N-1:0]  m_pdp = '0, m_adp = '0;
    logic [6:0]    e_seg = 7'h7F;
    logic          e_dp = 1'b1;
    logic [N-1:0]  e_an = '1;
    logic          e_fs = 1'b0;

    function automatic int ref_msd(input logic [VW-1:0] v);
        int m = 0;
        for (int i = 0; i < N; i++) if (((v >> (4 * i)) & 'hF) != 0) m = i;
        return m;
    endfunction

    task automatic model_edge();
        int digit, phase, nibv;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fs = 1'b0;
            cnt = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
            return;
        end
        digit = cnt / D;
        phase = cnt % D;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fs = 1'b0;
        if (bus.en) begin
            e_fs = (cnt == 0);
            if (phase >= B) begin
                nibv  = int'((m_act >> (4 * digit)) & 'hF);
                e_an  = ~(N'(1) << digit);
                e_seg = glyph[nibv];
`ifdef SEVENSEG_LZB_EN
                if (digit > ref_msd(m_act)) e_seg = 7'h7F;
`endif
                e_dp  = ~m_adp[digit];
            end
        end
        if (!bus.en || (digit == N - 1 && phase == D - 1)) begin
            m_act = bus.load ? bus.value_in : m_pend;
            m_adp = bus.load ? bus.dp_in    : m_pdp;
        end
        if (bus.load) begin
            m_pend = bus.value_in;
            m_pdp  = bus.dp_in;
        end
        cnt = bus.en ? (cnt + 1) % FRAME : 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_eq("seg", 32'(bus.seg), 32'(e_seg));
        check_eq("dp",  32'(bus.dp),  32'(e_dp));
        check_eq("an",  32'(bus.an),  32'(e_an));
        check_eq("frame_start", 32'(bus.frame_start), 32'(e_fs));
    endtask

    task automatic do_load(input logic [VW-1:0] v, input logic [N-1:0] d);
        bus.load = 1'b1; bus.value_in = v; bus.dp_in = d;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (cnt != target && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
        check_eq("run_to_bound", 32'(cnt), 32'(target));
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Basic scan of 1234.
        bus.en = 1'b1;
        do_load(16'h1234, 4'b0000);
        repeat (2 * FRAME + 2) tick();

        // Two loads inside one frame: only the last one appears next frame.
        run_to(5);
        do_load(16'hABCD, 4'b0101);
        run_to(10);
        do_load(16'hEF01, 4'b0010);
        repeat (2 * FRAME) tick();

        // Load on the exact boundary cycle takes the bypass.
        run_to(FRAME - 1);
        do_load(16'h5555, 4'b1111);
        repeat (FRAME + 2) tick();

        // Disable mid-frame with a load while disabled.
        run_to(6);
        bus.en = 1'b0;
        repeat (4) tick();
        do_load(16'h9876, 4'b0001);
        repeat (5) tick();
        bus.en = 1'b1;
        repeat (FRAME + 2) tick();

        // Reset during digit 2.
        run_to(2 * D + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (FRAME + 2) tick();

        // Leading-zero pattern.
        do_load(16'h0070, 4'b1000);
        repeat (2 * FRAME + 2) tick();
        do_load(16'h0000, 4'b0000);
        repeat (2 * FRAME + 2) tick();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 7) == 0) begin
                bus.load     = 1'b1;
                bus.value_in = VW'($urandom) >> (4 * $urandom_range(0, N - 1));
                bus.dp_in    = N'($urandom);
            end
            tick();
            rst = 1'b0;
            bus.load = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
